// File: rtl/ram_arbiter_if.sv
// Bus bundle between the video fetcher, the CPU, the single-port RAM and ram_arbiter.
// The arbiter side uses the slave modport; the requesters/RAM side uses master.
interface ram_arbiter_if #(
  parameter int Bits = 16
);
  logic            vidReq;
  logic [Bits-1:0] vidAddr;
  logic            vidAck;
  logic [7:0]      vidData;
  logic            cpuReq;
  logic            cpuWe;
  logic [Bits-1:0] cpuAddr;
  logic [7:0]      cpuDataIn;
  logic            cpuAck;
  logic [7:0]      cpuDataOut;
  logic [Bits-1:0] ramAddr;
  logic [7:0]      ramDataOut;
  logic            ramWe;
  logic [7:0]      ramDataIn;
  logic [1:0]      grantId;

  modport slave (
    input  vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuDataIn, ramDataIn,
    output vidAck, vidData, cpuAck, cpuDataOut, ramAddr, ramDataOut, ramWe, grantId
  );

  modport master (
    output vidReq, vidAddr, cpuReq, cpuWe, cpuAddr, cpuDataIn, ramDataIn,
    input  vidAck, vidData, cpuAck, cpuDataOut, ramAddr, ramDataOut, ramWe, grantId
  );
endinterface

// File: rtl/ram_arbiter.sv
// Fixed-priority arbiter sharing one single-port 8-bit RAM between the video fetcher and the CPU.
// Each ack flop doubles as that requester's rest flag, so neither can win two cycles in a row.
module ram_arbiter #(
  parameter int Bits = 16
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_VID  = 2'b01,
    GRANT_CPU  = 2'b10
  } grant_e;

  logic            vid_grant;
  logic            cpu_grant;
  logic [Bits-1:0] ram_addr;
  logic [7:0]      ram_data_out;
  logic            ram_we;

  logic       vid_ack_q, vid_ack_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic [7:0] vid_data_q, vid_data_d;
  logic [7:0] cpu_data_q, cpu_data_d;
  grant_e     grant_id_q, grant_id_d;

  // Grants are gated by reset so the RAM sees no write while reset is held.
  always_comb begin
    vid_grant    = reset & bus.vidReq & ~vid_ack_q;
    cpu_grant    = reset & bus.cpuReq & ~cpu_ack_q & ~vid_grant;
    ram_addr     = '0;
    ram_data_out = '0;
    ram_we       = 1'b0;
    if (vid_grant) begin
      ram_addr = bus.vidAddr;
    end else if (cpu_grant) begin
      ram_addr     = bus.cpuAddr;
      ram_data_out = bus.cpuDataIn;
      ram_we       = bus.cpuWe;
    end
  end

  always_comb begin
    vid_ack_d  = vid_grant;
    cpu_ack_d  = cpu_grant;
    vid_data_d = vid_grant ? bus.ramDataIn : vid_data_q;
    cpu_data_d = (cpu_grant && !bus.cpuWe) ? bus.ramDataIn : cpu_data_q;
    grant_id_d = GRANT_NONE;
    if (vid_grant) begin
      grant_id_d = GRANT_VID;
    end else if (cpu_grant) begin
      grant_id_d = GRANT_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
      grant_id_q <= GRANT_NONE;
    end else begin
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_data_q <= vid_data_d;
      cpu_data_q <= cpu_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.vidAck     = vid_ack_q;
  assign bus.vidData    = vid_data_q;
  assign bus.cpuAck     = cpu_ack_q;
  assign bus.cpuDataOut = cpu_data_q;
  assign bus.ramAddr    = ram_addr;
  assign bus.ramDataOut = ram_data_out;
  assign bus.ramWe      = ram_we;
  assign bus.grantId    = grant_id_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a cycle-level reference model queues expected acks,
// a negedge monitor compares the DUT bus against it every cycle.
module tb_ram_arbiter;
  localparam int Bits = 16;

  logic clk = 1'b0;
  logic reset;

  ram_arbiter_if #(.Bits(Bits)) bus ();
  ram_arbiter #(.Bits(Bits)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // RAM seen by the DUT: combinational read, write on the clock edge.
  logic [7:0] dut_ram [0:65535];
  assign bus.ramDataIn = dut_ram[bus.ramAddr];
  always @(posedge clk) if (bus.ramWe) dut_ram[bus.ramAddr] <= bus.ramDataOut;

  // Reference model state: memory contents, cycle of each requester's last service.
  logic [7:0] ref_mem [0:65535];
  int         last_vid = -10;
  int         last_cpu = -10;
  logic [1:0] exp_gid  = 2'b00;
  logic [7:0] m_cpu_out = 8'h00;

  typedef struct {
    int         due;
    logic [7:0] data;
  } resp_t;
  resp_t vid_q[$];
  resp_t cpu_q[$];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dut_ram[i] <= 8'(i);
      ref_mem[i] = 8'(i);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Who owns the RAM this cycle: a requester served in the previous cycle must rest,
  // and video wins any tie. 0 = nobody, 1 = video, 2 = CPU.
  function automatic int pick();
    bit v_ok, c_ok;
    v_ok = reset === 1'b1 && bus.vidReq === 1'b1 && last_vid != cyc - 1;
    c_ok = reset === 1'b1 && bus.cpuReq === 1'b1 && last_cpu != cyc - 1;
    if (v_ok) return 1;
    if (c_ok) return 2;
    return 0;
  endfunction

  // Model commit at the edge that ends cycle cyc.
  always @(posedge clk) begin
    int who;
    if (reset !== 1'b1) begin
      last_vid  = -10;
      last_cpu  = -10;
      exp_gid   = 2'b00;
      m_cpu_out = 8'h00;
    end else begin
      who = pick();
      if (who == 1) begin
        vid_q.push_back('{due: cyc + 1, data: ref_mem[bus.vidAddr]});
        last_vid = cyc;
        exp_gid  = 2'b01;
      end else if (who == 2) begin
        if (bus.cpuWe) ref_mem[bus.cpuAddr] = bus.cpuDataIn;
        else m_cpu_out = ref_mem[bus.cpuAddr];
        cpu_q.push_back('{due: cyc + 1, data: m_cpu_out});
        last_cpu = cyc;
        exp_gid  = 2'b10;
      end else begin
        exp_gid = 2'b00;
      end
    end
    cyc++;
  end

  // Monitor: compares every cycle, popping expected responses when they fall due.
  logic [7:0] vid_held = 8'h00;
  logic [7:0] cpu_held = 8'h00;
  always @(negedge clk) begin
    int         who;
    bit         exp_v, exp_c;
    resp_t      r;
    logic [Bits-1:0] e_addr;
    logic [7:0] e_data;
    logic       e_we;
    if (reset !== 1'b1) begin
      check("reset_outputs",
            {bus.vidAck, bus.cpuAck, bus.vidData, bus.cpuDataOut, bus.grantId,
             bus.ramWe, bus.ramAddr, bus.ramDataOut}, '0);
      vid_q.delete();
      cpu_q.delete();
      vid_held = 8'h00;
      cpu_held = 8'h00;
    end else begin
      check("grant_id", bus.grantId, exp_gid);
      who    = pick();
      e_addr = '0;
      e_data = '0;
      e_we   = 1'b0;
      if (who == 1) begin
        e_addr = bus.vidAddr;
      end else if (who == 2) begin
        e_addr = bus.cpuAddr;
        e_data = bus.cpuDataIn;
        e_we   = bus.cpuWe;
      end
      check("ram_we", bus.ramWe, e_we);
      check("ram_addr", bus.ramAddr, e_addr);
      if (who != 1) check("ram_wdata", bus.ramDataOut, e_data);

      exp_v = vid_q.size() > 0 && vid_q[0].due == cyc;
      check("vid_ack", bus.vidAck, exp_v);
      if (exp_v) begin
        r = vid_q.pop_front();
        vid_held = r.data;
      end
      check("vid_data", bus.vidData, vid_held);

      exp_c = cpu_q.size() > 0 && cpu_q[0].due == cyc;
      check("cpu_ack", bus.cpuAck, exp_c);
      if (exp_c) begin
        r = cpu_q.pop_front();
        cpu_held = r.data;
      end
      check("cpu_data", bus.cpuDataOut, cpu_held);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned a;
    a = $urandom_range(7);
    return (a < 4) ? 16'(a) : 16'h2000 + 16'(a);
  endfunction

  // Requesters that start a new access (or idle) in the cycle after each ack.
  task automatic run_traffic(int n, int p_vid, int p_cpu, bit cpu_write_ok);
    bit v_done = 1'b0;
    bit c_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (v_done || !bus.vidReq) begin
        v_done = 1'b0;
        if ($urandom_range(99) < p_vid) begin
          bus.vidReq  = 1'b1;
          bus.vidAddr = rand_addr();
        end else begin
          bus.vidReq = 1'b0;
        end
      end
      if (c_done || !bus.cpuReq) begin
        c_done = 1'b0;
        if ($urandom_range(99) < p_cpu) begin
          bus.cpuReq    = 1'b1;
          bus.cpuWe     = cpu_write_ok ? 1'($urandom_range(1)) : 1'b0;
          bus.cpuAddr   = rand_addr();
          bus.cpuDataIn = 8'($urandom_range(255));
        end else begin
          bus.cpuReq = 1'b0;
        end
      end
      if (bus.vidAck) v_done = 1'b1;
      if (bus.cpuAck) c_done = 1'b1;
    end
  endtask

  task automatic drain();
    int guard  = 0;
    bit v_done = 1'b0;
    bit c_done = 1'b0;
    while ((bus.vidReq || bus.cpuReq) && guard < 20) begin
      tick();
      guard++;
      if (v_done) bus.vidReq = 1'b0;
      if (c_done) bus.cpuReq = 1'b0;
      v_done = bus.vidAck;
      c_done = bus.cpuAck;
    end
    check("drain_timeout", guard >= 20, 0);
  endtask

  task automatic cpu_access(bit we, logic [15:0] a, logic [7:0] d);
    int guard = 0;
    bus.cpuReq = 1'b1; bus.cpuWe = we; bus.cpuAddr = a; bus.cpuDataIn = d;
    do begin tick(); guard++; end while (!bus.cpuAck && guard < 10);
    check("cpu_ack_timeout", guard >= 10, 0);
    tick();
    bus.cpuReq = 1'b0;
  endtask

  task automatic vid_read(logic [15:0] a);
    int guard = 0;
    bus.vidReq = 1'b1; bus.vidAddr = a;
    do begin tick(); guard++; end while (!bus.vidAck && guard < 10);
    check("vid_ack_timeout", guard >= 10, 0);
    tick();
    bus.vidReq = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.vidReq = 1'b1; bus.vidAddr = 16'h0004;
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 16'h0010; bus.cpuDataIn = 8'h77;
    repeat (3) tick();
    check("reset_no_write", dut_ram[16'h0010], 8'h10);
    bus.cpuWe = 1'b0;
    tick();
    reset = 1'b1;

    // Both requesting continuously, reads only: strict video/CPU alternation.
    run_traffic(20, 100, 100, 1'b0);
    drain();

    cpu_access(1'b1, 16'h2000, 8'hA5);
    vid_read(16'h2000);
    check("write_then_read", bus.vidData, 8'hA5);

    vid_read(16'h0003);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_vid_data", bus.vidData, 8'h03);
      check("hold_vid_ack", bus.vidAck, 0);
    end

    // Reset dropped inside a CPU write grant cycle, before the closing edge.
    bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 16'h0005; bus.cpuDataIn = 8'h5A;
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_cpu_ack", bus.cpuAck, 0);
      check("midreset_grant_id", bus.grantId, 0);
    end
    bus.cpuReq = 1'b0;
    check("midreset_mem", dut_ram[16'h0005], 8'h05);
    tick();
    reset = 1'b1;

    run_traffic(30, 0, 100, 1'b1);
    drain();
    run_traffic(400, 60, 60, 1'b1);
    drain();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 8-bit video/system RAM between the video fetcher and the CPU. It takes level requests from both masters, grants at most one RAM access per cycle, drives the RAM's `address`/`dataIn`/`writeEnabled` lines, and returns registered read data with a one-cycle acknowledge. The video fetcher has fixed priority. A mandatory per-requester rest cycle after each grant guarantees the CPU at least every other RAM cycle.

## Interface

Parameters:
- `Bits`, 16, RAM address width (must match the RAM instance).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `vidReq`  input  1  video read request, level; held until `vidAck`.
- `vidAddr`  input  Bits  video read address; stable while `vidReq` is high.
- `vidAck`  output  1  one-cycle pulse; `vidData` is valid in this cycle.
- `vidData`  output  8  last video read data; holds until the next `vidAck`.
- `cpuReq`  input  1  CPU request, level; held until `cpuAck`.
- `cpuWe`  input  1  1 = write, 0 = read; stable with `cpuReq`.
- `cpuAddr`  input  Bits  CPU address.
- `cpuDataIn`  input  8  CPU write data.
- `cpuAck`  output  1  one-cycle pulse; access is complete, and read data is valid for reads.
- `cpuDataOut`  output  8  last CPU read data; unchanged by writes.
- `ramAddr`  output  Bits  to RAM `address`.
- `ramDataOut`  output  8  to RAM `dataIn`.
- `ramWe`  output  1  to RAM `writeEnabled`.
- `ramDataIn`  input  8  from RAM `dataOut` (combinational read).
- `grantId`  output  2  registered: 00 none, 01 video, 10 CPU granted in the previous cycle.

## Operation

- Grant logic is combinational in cycle N. The registered state (`vidAck`, `cpuAck`) is the rest-flag for each requester.
  - `vidGrant = reset & vidReq & ~vidAck`
  - `cpuGrant = reset & cpuReq & ~cpuAck & ~vidGrant`
- RAM drive:
  - On `vidGrant`: `ramAddr=vidAddr`, `ramWe=0`.
  - On `cpuGrant`: `ramAddr=cpuAddr`, `ramDataOut=cpuDataIn`, `ramWe=cpuWe`.
  - With no grant: `ramAddr=0`, `ramDataOut=0`, `ramWe=0`.
- On the rising edge that ends cycle N:
  - Video grant: `vidData<=ramDataIn`, `vidAck<=1`.
  - CPU read: `cpuDataOut<=ramDataIn`, `cpuAck<=1`.
  - CPU write: the RAM latches the data on this same edge, and `cpuAck<=1`.
  - Any ack not set by this edge clears to 0.
- Rest cycle: a requester is never granted in its own ack cycle. Its `req`/`addr` are still the old values in that cycle. The other requester may be granted in it.
- Requesters sample the ack at the end of the ack cycle. They then drop `req` or present a new access from the following cycle.
- Priority: video beats CPU whenever both are eligible. There is no other state, counter, or fairness logic.
- `grantId` is updated each edge from the grant decision of the cycle just ended.

## Timing

- Latency: the request is granted in the first eligible cycle N; the ack and data appear in N+1.
- Read data is captured from the RAM's combinational output in the grant cycle.
- Read-after-write: a CPU write in cycle N is visible to any read granted in N+1 or later.
- Throughput:
  - Each requester gets at most one access per 2 cycles.
  - Combined, the RAM is used every cycle when both requesters hold requests.
  - Worst-case CPU wait with video requesting continuously is 1 cycle.
- Simultaneous requests from idle: video is granted at N and CPU at N+1. `vidAck` asserts at N+1 and `cpuAck` at N+2.
- Reset values, asynchronous on `reset=0`:
  - `vidAck=0`, `cpuAck=0`, `vidData=0`, `cpuDataOut=0`, `grantId=00`.
  - `ramWe=0` and no grants for as long as `reset=0`.
- Reset mid-access: a pending ack is dropped and is not re-issued. Requesters re-request after reset is released.
- Reset release: the first grant is possible in the first cycle with `reset=1`.
- A request dropped before its grant is legal and has no effect. Dropping a request in the grant cycle itself is illegal.

## Test plan

- **Reset:** assert `reset=0` with both requests high.
  - Required: all outputs stay 0, `ramWe=0`, and no RAM write occurs.
  - Release reset: `vidAck` at cycle 2 and `cpuAck` at cycle 3.
- **Priority and interleave:**
  - Stimulus: both requesters hold requests continuously with `cpuWe=0`.
  - Required: `grantId` sequence 01,10,01,10…, `vidAck`/`cpuAck` alternating every cycle, and `ramWe` never 1.
- **Write then read:**
  - Stimulus: CPU writes 0xA5 to 0x2000, then video reads 0x2000.
  - Required: `vidData=0xA5` with `vidAck`, and `cpuDataOut` unchanged by the write.
- **Read data hold:**
  - Stimulus: video reads 0x0003 (preloaded 0x03), then idles for 5 cycles.
  - Required: `vidData=0x03` is held for all 5 cycles while `vidAck=0`.
- **Mid-access reset:**
  - Stimulus: pull `reset` low in a CPU write grant cycle, before the edge.
  - Required: the RAM location is unchanged, `cpuAck` is never asserted, and `grantId=00`.
- **Lone CPU back-to-back:**
  - Stimulus: CPU holds its request with a new address after each ack.
  - Required: `cpuAck` on every second cycle, and RAM writes occur only in the grant cycles.
